// File: rtl/ay_bus_pkg.sv
// Shared types and constants for the AY-3-891x BDIR/BC1 bus master.
// Bus modes are encoded as {bdir, bc1}.
package ay_bus_pkg;

    localparam logic [1:0] BUS_INACTIVE = 2'b00;
    localparam logic [1:0] BUS_READ     = 2'b01;
    localparam logic [1:0] BUS_WRITE    = 2'b10;
    localparam logic [1:0] BUS_LATCH    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_GAP_L,
        ST_WRITE,
        ST_GAP_W
    } state_t;

    localparam logic [3:0] R_TONE_A_FINE   = 4'd0;
    localparam logic [3:0] R_TONE_A_COARSE = 4'd1;
    localparam logic [3:0] R_TONE_B_FINE   = 4'd2;
    localparam logic [3:0] R_TONE_B_COARSE = 4'd3;
    localparam logic [3:0] R_TONE_C_FINE   = 4'd4;
    localparam logic [3:0] R_TONE_C_COARSE = 4'd5;
    localparam logic [3:0] R_NOISE_PERIOD  = 4'd6;
    localparam logic [3:0] R_MIXER         = 4'd7;
    localparam logic [3:0] R_AMP_A         = 4'd8;
    localparam logic [3:0] R_AMP_B         = 4'd9;
    localparam logic [3:0] R_AMP_C         = 4'd10;
    localparam logic [3:0] R_ENV_FINE      = 4'd11;
    localparam logic [3:0] R_ENV_COARSE    = 4'd12;
    localparam logic [3:0] R_ENV_SHAPE     = 4'd13;

    typedef struct packed {
        logic [3:0] regnum;
        logic [7:0] data;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/ay_cmd_fifo.sv
// Synchronous command FIFO with registered storage.
// The head entry is presented combinationally on dout.
module ay_cmd_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign dout    = mem[rd_ptr];

    // Storage write; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ay_bus_master.sv
// Initiator for the AY-3-891x BDIR/BC1 bus: replays queued
// (register, value) writes as latch / gap / write / gap sequences.
module ay_bus_master #(
    parameter logic [3:0] CHIP_MASK            = 4'b0000,
    parameter int         FIFO_DEPTH           = 4,
    parameter int         PHASE_CYCLES         = 1,
    parameter int         GAP_CYCLES           = 1,
    parameter bit         SKIP_REDUNDANT_LATCH = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [3:0]                    cmd_reg,
    input  logic [7:0]                    cmd_data,
    output logic [7:0]                    bus_data,
    output logic                          bdir,
    output logic                          bc1,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    import ay_bus_pkg::*;

    localparam logic [3:0] PHASE_LD = 4'(PHASE_CYCLES - 1);
    localparam logic [3:0] GAP_LD   = 4'(GAP_CYCLES - 1);

    state_t           state;
    state_t           state_d;
    logic [3:0]       cnt;
    logic [3:0]       cnt_d;
    cmd_t             cur;
    cmd_t             cur_d;
    cmd_t             head;
    logic [CMD_W-1:0] head_raw;
    logic             pop;
    logic             full;
    logic             empty;
    logic             cache_valid;
    logic             cache_valid_d;
    logic [3:0]       cache_reg;
    logic [3:0]       cache_reg_d;
    logic             phase_done;
    logic             skip_latch;
    logic [1:0]       mode_d;
    logic [7:0]       data_d;

    ay_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_valid),
        .pop   (pop),
        .din   ({cmd_reg, cmd_data}),
        .dout  (head_raw),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    assign head       = cmd_t'(head_raw);
    assign cmd_ready  = !full;
    assign busy       = (state != ST_IDLE) || !empty;
    assign phase_done = (cnt == 4'd0);
    assign skip_latch = SKIP_REDUNDANT_LATCH && cache_valid
                        && (head.regnum == cache_reg);

    // State, hold counter, current command and latch cache registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            cur         <= '0;
            cache_valid <= 1'b0;
            cache_reg   <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            cur         <= cur_d;
            cache_valid <= cache_valid_d;
            cache_reg   <= cache_reg_d;
        end
    end

    // Next state: phases advance when the hold counter expires; a pop
    // from IDLE or the final gap cycle starts the next command directly.
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        cur_d         = cur;
        pop           = 1'b0;
        cache_valid_d = cache_valid;
        cache_reg_d   = cache_reg;
        unique case (state)
            ST_IDLE: begin
                if (!empty) pop = 1'b1;
            end
            ST_LATCH: begin
                if (phase_done) state_d = ST_GAP_L;
            end
            ST_GAP_L: begin
                if (phase_done) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (phase_done) state_d = ST_GAP_W;
            end
            ST_GAP_W: begin
                if (phase_done) begin
                    if (!empty) pop = 1'b1;
                    else        state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (pop) begin
            cur_d = head;
            if (skip_latch) begin
                state_d = ST_WRITE;
            end else begin
                state_d       = ST_LATCH;
                cache_valid_d = 1'b1;
                cache_reg_d   = head.regnum;
            end
        end
        if (state_d != state) begin
            cnt_d = (state_d == ST_LATCH || state_d == ST_WRITE)
                    ? PHASE_LD : GAP_LD;
        end else if (!phase_done) begin
            cnt_d = cnt - 4'd1;
        end
    end

    // Bus value for the upcoming cycle; read mode is never produced.
    always_comb begin
        mode_d = BUS_INACTIVE;
        data_d = 8'h00;
        unique case (state_d)
            ST_LATCH: begin
                mode_d = BUS_LATCH;
                data_d = {CHIP_MASK, cur_d.regnum};
            end
            ST_WRITE: begin
                mode_d = BUS_WRITE;
                data_d = cur_d.data;
            end
            default: begin
                mode_d = BUS_INACTIVE;
                data_d = 8'h00;
            end
        endcase
    end

    // Registered bus outputs so the PSG sees glitch-free edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            {bdir, bc1} <= BUS_INACTIVE;
            bus_data    <= 8'h00;
        end else begin
            {bdir, bc1} <= mode_d;
            bus_data    <= data_d;
        end
    end

endmodule

// File: tb/tb_ay_bus_master.sv
// Bench for ay_bus_master: four parameter variants, a transaction-level
// bus model per variant, and a minimal PSG register-file listener.
module tb_ay_bus_master;

    localparam int N     = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic       started;
    int         n_cmp;
    int         n_bad;

    logic       cmd_valid_s  [N];
    logic       cmd_ready_s  [N];
    logic [3:0] cmd_reg_s    [N];
    logic [7:0] cmd_data_s   [N];
    logic [7:0] bus_data_s   [N];
    logic       bdir_s       [N];
    logic       bc1_s        [N];
    logic       busy_s       [N];
    logic [2:0] fifo_level_s [N];

    localparam logic [9:0] E4 [10] = '{
        10'h30D, 10'h30D, 10'h30D, 10'h000, 10'h000,
        10'h20E, 10'h20E, 10'h20E, 10'h000, 10'h000
    };

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : inst
        localparam int         PH = (g == 2) ? 3 : 1;
        localparam int         GP = (g == 2) ? 2 : 1;
        localparam bit         SK = (g == 1) ? 1'b0 : 1'b1;
        localparam logic [3:0] CM = (g == 3) ? 4'hA : 4'h0;

        ay_bus_master #(
            .CHIP_MASK            (CM),
            .FIFO_DEPTH           (DEPTH),
            .PHASE_CYCLES         (PH),
            .GAP_CYCLES           (GP),
            .SKIP_REDUNDANT_LATCH (SK)
        ) dut (
            .clk        (clk),
            .reset      (reset),
            .cmd_valid  (cmd_valid_s[g]),
            .cmd_ready  (cmd_ready_s[g]),
            .cmd_reg    (cmd_reg_s[g]),
            .cmd_data   (cmd_data_s[g]),
            .bus_data   (bus_data_s[g]),
            .bdir       (bdir_s[g]),
            .bc1        (bc1_s[g]),
            .busy       (busy_s[g]),
            .fifo_level (fifo_level_s[g])
        );

        logic [11:0] q    [$];
        logic [9:0]  expq [$];
        logic [9:0]  exp_bus;
        bit          active;
        bit          cache_v;
        logic [3:0]  cache_r;
        logic [7:0]  psg [16];
        bit          sel;
        logic [3:0]  addr;
        int          lat_cnt;
        bit          saw_full;

        initial begin
            for (int k = 0; k < 16; k++) psg[k] = 8'h00;
            sel      = 1'b0;
            addr     = 4'h0;
            lat_cnt  = 0;
            saw_full = 1'b0;
            active   = 1'b0;
            cache_v  = 1'b0;
            cache_r  = 4'h0;
            exp_bus  = '0;
        end

        // Transaction model: each popped command expands to its list of
        // bus cycles; the next command is taken once that list runs out.
        always @(posedge clk) begin
            bit          psh;
            logic [11:0] c;
            psh = cmd_valid_s[g] && (q.size() < DEPTH);
            if (reset) begin
                q.delete();
                expq.delete();
                active  = 1'b0;
                exp_bus = '0;
                cache_v = 1'b0;
            end else begin
                if (expq.size() == 0 && q.size() > 0) begin
                    c = q.pop_front();
                    if (!(SK && cache_v && cache_r == c[11:8])) begin
                        cache_v = 1'b1;
                        cache_r = c[11:8];
                        for (int n = 0; n < PH; n++)
                            expq.push_back({2'b11, CM, c[11:8]});
                        for (int n = 0; n < GP; n++)
                            expq.push_back(10'h000);
                    end
                    for (int n = 0; n < PH; n++)
                        expq.push_back({2'b10, c[7:0]});
                    for (int n = 0; n < GP; n++)
                        expq.push_back(10'h000);
                end
                if (expq.size() > 0) begin
                    exp_bus = expq.pop_front();
                    active  = 1'b1;
                end else begin
                    exp_bus = '0;
                    active  = 1'b0;
                end
                if (psh) q.push_back({cmd_reg_s[g], cmd_data_s[g]});
            end
        end

        // PSG listener with chip mask 0000.
        always @(negedge clk) begin
            if ({bdir_s[g], bc1_s[g]} == 2'b11) begin
                lat_cnt++;
                if (bus_data_s[g][7:4] == 4'h0) begin
                    sel  = 1'b1;
                    addr = bus_data_s[g][3:0];
                end else begin
                    sel = 1'b0;
                end
            end else if ({bdir_s[g], bc1_s[g]} == 2'b10 && sel) begin
                psg[addr] = bus_data_s[g];
            end
            if (fifo_level_s[g] == 3'd4 && !cmd_ready_s[g])
                saw_full = 1'b1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_one(input int i, input logic [9:0] eb,
                           input bit act, input int ql);
        check($sformatf("bus[%0d]", i),
              int'({bdir_s[i], bc1_s[i], bus_data_s[i]}), int'(eb));
        check($sformatf("busy[%0d]", i), int'(busy_s[i]),
              int'(act || ql > 0));
        check($sformatf("level[%0d]", i), int'(fifo_level_s[i]), ql);
        check($sformatf("ready[%0d]", i), int'(cmd_ready_s[i]),
              int'(ql < DEPTH));
        check($sformatf("no_read_mode[%0d]", i),
              int'({bdir_s[i], bc1_s[i]} == 2'b01), 0);
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (started) begin
                cmp_one(0, inst[0].exp_bus, inst[0].active, inst[0].q.size());
                cmp_one(1, inst[1].exp_bus, inst[1].active, inst[1].q.size());
                cmp_one(2, inst[2].exp_bus, inst[2].active, inst[2].q.size());
                cmp_one(3, inst[3].exp_bus, inst[3].active, inst[3].q.size());
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input int i, input logic [3:0] r, input logic [7:0] d);
        int t;
        t = 0;
        cmd_valid_s[i] = 1'b1;
        cmd_reg_s[i]   = r;
        cmd_data_s[i]  = d;
        while (!cmd_ready_s[i] && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("push_timeout", int'(t >= 200), 0);
        @(posedge clk);
        @(negedge clk);
        cmd_valid_s[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int t;
        t = 0;
        while (busy_s[i] && t < 300) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("idle_timeout[%0d]", i), int'(busy_s[i]), 0);
    endtask

    task automatic bus_is(input string name, input int i, input logic [9:0] e);
        check(name, int'({bdir_s[i], bc1_s[i], bus_data_s[i]}), int'(e));
    endtask

    initial begin
        int lat0;
        int t;
        n_cmp   = 0;
        n_bad   = 0;
        started = 1'b0;
        reset   = 1'b1;
        for (int i = 0; i < N; i++) begin
            cmd_valid_s[i] = 1'b0;
            cmd_reg_s[i]   = 4'h0;
            cmd_data_s[i]  = 8'h00;
        end
        fork
            compare_loop();
        join_none
        repeat (2) @(negedge clk);
        started = 1'b1;
        reset   = 1'b0;

        bus_is("rst_bus", 0, 10'h000);
        check("rst_level", int'(fifo_level_s[0]), 0);
        check("rst_ready", int'(cmd_ready_s[0]), 1);
        check("rst_busy", int'(busy_s[0]), 0);

        push(0, 4'd0, 8'h5A);
        @(negedge clk); bus_is("t1_e1_latch", 0, 10'h300);
        @(negedge clk); bus_is("t1_e2_gap", 0, 10'h000);
        @(negedge clk); bus_is("t1_e3_write", 0, 10'h25A);
        @(negedge clk); bus_is("t1_e4_gap", 0, 10'h000);
        check("t1_e4_busy", int'(busy_s[0]), 1);
        @(negedge clk);
        check("t1_e5_busy", int'(busy_s[0]), 0);
        check("t1_psg_r0", int'(inst[0].psg[0]), 8'h5A);

        lat0 = inst[0].lat_cnt;
        push(0, 4'd8, 8'h0F);
        push(0, 4'd8, 8'h1F);
        wait_idle(0);
        check("t2_skip_latches", inst[0].lat_cnt - lat0, 1);
        check("t2_skip_psg_r8", int'(inst[0].psg[8]), 8'h1F);
        lat0 = inst[1].lat_cnt;
        push(1, 4'd8, 8'h0F);
        push(1, 4'd8, 8'h1F);
        wait_idle(1);
        check("t2_noskip_latches", inst[1].lat_cnt - lat0, 2);
        check("t2_noskip_psg_r8", int'(inst[1].psg[8]), 8'h1F);

        for (int k = 0; k < 6; k++)
            push(0, 4'(k), 8'(8'h10 + k));
        wait_idle(0);
        check("t3_saw_full", int'(inst[0].saw_full), 1);
        for (int k = 0; k < 6; k++)
            check($sformatf("t3_psg_r%0d", k), int'(inst[0].psg[k]), 8'h10 + k);

        push(2, 4'd13, 8'h0E);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus_is($sformatf("t4_cycle%0d", k + 1), 2, E4[k]);
        end
        @(negedge clk);
        check("t4_busy_end", int'(busy_s[2]), 0);
        check("t4_psg_r13", int'(inst[2].psg[13]), 8'h0E);

        push(0, 4'd7, 8'h38);
        push(0, 4'd1, 8'h11);
        push(0, 4'd2, 8'h22);
        t = 0;
        while ({bdir_s[0], bc1_s[0]} != 2'b10 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("t5_in_write", int'({bdir_s[0], bc1_s[0]}), 2);
        check("t5_queued", int'(fifo_level_s[0]), 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus_is("t5_bus_after_rst", 0, 10'h000);
        check("t5_level_after_rst", int'(fifo_level_s[0]), 0);
        check("t5_busy_after_rst", int'(busy_s[0]), 0);
        lat0 = inst[0].lat_cnt;
        push(0, 4'd7, 8'h3F);
        wait_idle(0);
        check("t5_relatch", inst[0].lat_cnt - lat0, 1);
        check("t5_psg_r7", int'(inst[0].psg[7]), 8'h3F);

        push(3, 4'd1, 8'h0F);
        @(negedge clk);
        bus_is("t6_latch_mask", 3, 10'h3A1);
        wait_idle(3);
        check("t6_psg_r1", int'(inst[3].psg[1]), 8'h00);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ay_bus_master.md
Name: ay_bus_master

Overview:
- Host-side driver for the PSG's AY-3-891x style BDIR/BC1 bus, i.e. the initiator end of the interface the PSG core responds to.
- Accepts (register, value) write commands on a valid/ready stream and buffers them in a small FIFO.
- Replays each command as a bus sequence: Latch Register Address (tagged with the chip-select upper nibble), inactive gap, Write to Register Array, inactive gap.
- Used by the test harness and by a future sequencer/player block that streams register dumps into the PSG.

Parameters:
- CHIP_MASK, 4'b0000, value driven on bus_data[7:4] during the latch phase; must match the PSG's DA7..DA4 mask.
- FIFO_DEPTH, 4, command FIFO entries; power of 2, range 2..16.
- PHASE_CYCLES, 1, clk cycles each latch or write phase is held; range 1..15.
- GAP_CYCLES, 1, clk cycles of inactive bus after each phase; range 1..15.
- SKIP_REDUNDANT_LATCH, 1, when 1, omit the latch phase if the register equals the last latched register.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept a command (= !full)
- cmd_reg  in  4  target PSG register R0..R15
- cmd_data  in  8  value to write
- bus_data  out  8  PSG data bus (DA7..DA0)
- bdir  out  1  PSG BDIR
- bc1  out  1  PSG BC1
- busy  out  1  FSM not IDLE or FIFO non-empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently queued

Behaviour:
- Reset: synchronous, active-high. Effects:
  - bdir=0, bc1=0, bus_data=0
  - FIFO emptied; fifo_level=0; cmd_ready=1; busy=0
  - FSM=IDLE; latch cache invalidated
  - A reset mid-transaction aborts it; the bus is inactive the cycle after the reset edge.
- Push: occurs on an edge where cmd_valid && cmd_ready. Commands never drop or reorder. A command pushed while full is impossible, because ready is low.
- Simultaneous push and pop when full: cmd_ready is still 0, so no push happens. When neither full nor empty, both occur and fifo_level is unchanged.
- bdir, bc1 and bus_data are registered and change only on clk edges. {bdir,bc1} is never 01, because the read mode is unused.
- FSM states:
  - IDLE: bus inactive, bus_data=0. If the FIFO is non-empty, pop the head. If SKIP_REDUNDANT_LATCH && cache_valid && head.reg==cache_reg, go to WRITE; otherwise go to LATCH.
  - LATCH: {bdir,bc1}=11, bus_data={CHIP_MASK, reg}. Held PHASE_CYCLES cycles, then go to GAP_L. On entry, set cache_reg=reg and cache_valid=1.
  - GAP_L: {bdir,bc1}=00, bus_data=0. Held GAP_CYCLES cycles, then go to WRITE.
  - WRITE: {bdir,bc1}=10, bus_data=value. Held PHASE_CYCLES cycles, then go to GAP_W.
  - GAP_W: inactive, held GAP_CYCLES cycles. On the last cycle, if the FIFO is non-empty, pop and branch as in IDLE (back-to-back, no IDLE cycle); otherwise go to IDLE.
- Latency: a command pushed at edge k into an empty FIFO with FSM in IDLE is popped at edge k+1. Bus latch outputs are visible from edge k+1.
- Transaction length:
  - Full transaction: 2*PHASE_CYCLES + 2*GAP_CYCLES cycles.
  - Skipped-latch transaction: PHASE_CYCLES + GAP_CYCLES cycles.
- A single phase-cycle counter, 4 bits wide, reloads on every state entry.
- Per-phase hold counts are exact. The bench checks them cycle by cycle.
- fifo_level counts queued entries only; the command being driven is excluded.

Decomposition:
- Package ay_bus_pkg:
  - Bus mode constants as {bdir,bc1}: BUS_INACTIVE=2'b00, BUS_READ=2'b01, BUS_WRITE=2'b10, BUS_LATCH=2'b11.
  - FSM state enum.
  - Register index constants R_TONE_A_FINE..R_ENV_SHAPE (0..13).
  - Command struct {reg[3:0], data[7:0]}.
- Sub-module ay_cmd_fifo: synchronous FIFO with parameters WIDTH=12 and DEPTH. Ports push/pop/full/empty/level and dout, with registered storage and combinational head.

Test Plan:
1. Defaults (PHASE=1, GAP=1), single cmd (R0, 0x5A) pushed at edge 0. Expect:
   - edge 1: 11/0x00
   - edge 2: 00/0x00
   - edge 3: 10/0x5A
   - edge 4: 00
   - busy drops after edge 5
   - Attached PSG register[0] == 0x5A.
2. Redundant latch: (R8, 0x0F) then (R8, 0x1F) back-to-back, with SKIP=1. Expect the second command to produce only WRITE 10/0x1F with no LATCH, and the PSG R8 == 0x1F. Repeat with SKIP=0: two LATCH phases are observed.
3. Backpressure: push 6 cmds (R0..R5, data=0x10+i) in consecutive cycles with FIFO_DEPTH=4. Expect:
   - cmd_ready low while fifo_level==4.
   - All 6 are written in order; PSG R0..R5 == 0x10..0x15.
   - The bus never shows 01.
4. Timing params PHASE=3, GAP=2, cmd (R13, 0x0E). Expect 11 held exactly 3 cycles, 00 held 2, 10/0x0E held 3, 00 held 2 (10 cycles total). The PSG envelope restarts, and register[13] == 0x0E.
5. Reset during WRITE phase of (R7, 0x38) with 2 more cmds queued. Expect:
   - The bus goes 00/0x00 one cycle after the reset edge.
   - fifo_level=0, cache invalidated.
   - The next cmd (R7, 0x3F) performs a full LATCH despite the same register.
6. CHIP_MASK=4'b1010 driving a PSG instance with mask 4'b0000, cmd (R1, 0x0F). Expect the latch bus_data=0xA1, the PSG stays inactive, and PSG R1 is unchanged at 0.
